// File: rtl/ucom_boot_ctrl_if.sv
// Downloader, ROM-init and CPU-control signals of the boot controller.
// The master side is the downloader/board logic; the slave side is ucom_boot_ctrl.
interface ucom_boot_ctrl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        user_reset;
  logic        rom_init;
  logic [11:0] rom_init_addr;
  logic [7:0]  rom_init_data;
  logic        cpu_reset;
  logic        loaded;
  logic        size_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
    input  ioctl_wait, rom_init, rom_init_addr, rom_init_data, cpu_reset, loaded, size_err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
    output ioctl_wait, rom_init, rom_init_addr, rom_init_data, cpu_reset, loaded, size_err
  );
endinterface

// File: rtl/ucom_boot_ctrl.sv
// Loads a program image into ROM, zero-fills the unwritten tail (stalling the downloader),
// then holds the CPU in reset for HOLD_CYCLES; ROM writes appear one cycle after the strobe.
module ucom_boot_ctrl #(
  parameter int ROM_WORDS   = 2048,
  parameter int HOLD_CYCLES = 16
) (
  input logic             clk,
  input logic             reset,
  ucom_boot_ctrl_if.slave bus
);
  localparam int              CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [15:0]     ADDR_LIMIT = 16'(ROM_WORDS);
  localparam logic [12:0]     HWM_FULL   = 13'(ROM_WORDS);
  localparam logic [11:0]     LAST_ADDR  = 12'(ROM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_t;

  state_t        state, state_nxt;
  logic          dl_q;
  logic [12:0]   hwm, hwm_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          size_err_q, size_err_nxt;
  logic          loaded_q, loaded_nxt;
  logic          rom_init_q, rom_init_nxt;
  logic [11:0]   addr_q, addr_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          dl_rise, dl_fall, in_range;
  logic [12:0]   wr_top;

  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign dl_fall  = ~bus.ioctl_download & dl_q;
  assign in_range = bus.ioctl_addr < ADDR_LIMIT;
  assign wr_top   = {1'b0, bus.ioctl_addr[11:0]} + 13'd1;

  always_ff @(posedge clk) begin
    // Tracking the download level through reset stops a session still active at reset
    // release from being mistaken for a new one.
    dl_q <= bus.ioctl_download;
    if (reset) begin
      state      <= IDLE;
      hwm        <= '0;
      hold_cnt   <= '0;
      size_err_q <= 1'b0;
      loaded_q   <= 1'b0;
      rom_init_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nxt;
      hwm        <= hwm_nxt;
      hold_cnt   <= hold_cnt_nxt;
      size_err_q <= size_err_nxt;
      loaded_q   <= loaded_nxt;
      rom_init_q <= rom_init_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hwm_nxt      = hwm;
    hold_cnt_nxt = hold_cnt;
    size_err_nxt = size_err_q;
    loaded_nxt   = loaded_q;
    rom_init_nxt = 1'b0;
    addr_nxt     = addr_q;
    data_nxt     = data_q;

    if (dl_rise) begin
      // A new session wins over everything, including an unfinished fill.
      state_nxt    = LOAD;
      hwm_nxt      = '0;
      size_err_nxt = 1'b0;
      loaded_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (dl_fall) begin
            if (hwm == 13'd0) begin
              state_nxt    = IDLE;
              size_err_nxt = 1'b1;
            end else if (hwm < HWM_FULL) begin
              state_nxt    = FILL;
              rom_init_nxt = 1'b1;
              addr_nxt     = hwm[11:0];
              data_nxt     = 8'h00;
            end else begin
              state_nxt    = HOLD;
              hold_cnt_nxt = HOLD_LOAD;
            end
          end else if (bus.ioctl_wr) begin
            if (in_range) begin
              rom_init_nxt = 1'b1;
              addr_nxt     = bus.ioctl_addr[11:0];
              data_nxt     = bus.ioctl_dout;
              if (wr_top > hwm) hwm_nxt = wr_top;
            end else begin
              size_err_nxt = 1'b1;
            end
          end
        end
        FILL: begin
          if (addr_q == LAST_ADDR) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_LOAD;
          end else begin
            rom_init_nxt = 1'b1;
            addr_nxt     = addr_q + 12'd1;
          end
        end
        HOLD: begin
          if (bus.user_reset) begin
            hold_cnt_nxt = HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state_nxt  = RUN;
            loaded_nxt = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (bus.user_reset) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_LOAD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.ioctl_wait    = (state == FILL);
  assign bus.cpu_reset     = (state != RUN);
  assign bus.rom_init      = rom_init_q;
  assign bus.rom_init_addr = addr_q;
  assign bus.rom_init_data = data_q;
  assign bus.loaded        = loaded_q;
  assign bus.size_err      = size_err_q;
endmodule

// File: tb/tb_ucom_boot_ctrl.sv
// Scoreboard bench for ucom_boot_ctrl: stimulus queues expected ROM writes and cpu_reset
// edges from a cycle-level reference model; a negedge monitor pops and compares them.
module tb_ucom_boot_ctrl;
  localparam int ROM  = 2048;
  localparam int HOLD = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ucom_boot_ctrl_if bus();

  ucom_boot_ctrl #(.ROM_WORDS(ROM), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int cyc; bit fill; } wr_t;
  typedef struct { bit rise; int cyc; } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  errors   = 0;
  int  m_hwm    = 0;
  bit  m_err    = 1'b0;
  int  run_from = -1;   // cycle at which the model expects RUN to begin, -1 if none
  bit  prev_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ROM write and every cpu_reset edge must match the head of its queue.
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (bus.rom_init) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL rom_write: unexpected write addr=%0d data=%0d cycle=%0d",
                 bus.rom_init_addr, bus.rom_init_data, cyc);
      end else begin
        w = exp_wr.pop_front();
        if (int'(bus.rom_init_addr) != w.addr || int'(bus.rom_init_data) != w.data ||
            cyc != w.cyc || bus.ioctl_wait != w.fill) begin
          errors++;
          $display("FAIL rom_write: got addr=%0d data=%0d cycle=%0d wait=%0b, expected addr=%0d data=%0d cycle=%0d wait=%0b",
                   bus.rom_init_addr, bus.rom_init_data, cyc, bus.ioctl_wait, w.addr, w.data, w.cyc, w.fill);
        end
      end
    end else if (bus.ioctl_wait) begin
      checks++;
      errors++;
      $display("FAIL ioctl_wait: got 1 without a fill write at cycle %0d, expected 0", cyc);
    end
    if (bus.cpu_reset != prev_rst) begin
      checks++;
      if (exp_ev.size() == 0) begin
        errors++;
        $display("FAIL cpu_reset_edge: unexpected change to %0b at cycle %0d", bus.cpu_reset, cyc);
      end else begin
        e = exp_ev.pop_front();
        if (e.rise != bus.cpu_reset || e.cyc != cyc || (!bus.cpu_reset && !bus.loaded)) begin
          errors++;
          $display("FAIL cpu_reset_edge: got level=%0b cycle=%0d loaded=%0b, expected level=%0b cycle=%0d",
                   bus.cpu_reset, cyc, bus.loaded, e.rise, e.cyc);
        end
      end
    end
    prev_rst = bus.cpu_reset;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drop everything the model scheduled from cycle 'limit' on (abort or reset).
  task automatic purge(input int limit);
    while (exp_wr.size() > 0 && exp_wr[exp_wr.size()-1].cyc >= limit) exp_wr.delete(exp_wr.size()-1);
    while (exp_ev.size() > 0 && exp_ev[exp_ev.size()-1].cyc >= limit) exp_ev.delete(exp_ev.size()-1);
  endtask

  task automatic leave_run();
    if (run_from >= 0 && run_from <= cyc) exp_ev.push_back('{1'b1, cyc + 1});
    run_from = -1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.user_reset = 1'b0;
    purge(cyc + 1);
    leave_run();
    @(negedge clk);
    check({tag, "_rom_init"}, bus.rom_init, 0);
    check({tag, "_ioctl_wait"}, bus.ioctl_wait, 0);
    check({tag, "_cpu_reset"}, bus.cpu_reset, 1);
    check({tag, "_loaded"}, bus.loaded, 0);
    check({tag, "_size_err"}, bus.size_err, 0);
    check({tag, "_rom_addr"}, bus.rom_init_addr, 0);
    check({tag, "_rom_data"}, bus.rom_init_data, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_download();
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b0;
    purge(cyc + 1);
    leave_run();
    m_hwm = 0;
    m_err = 1'b0;
  endtask

  task automatic write_byte(input int addr, input int data);
    @(negedge clk);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 16'(addr);
    bus.ioctl_dout = 8'(data);
    if (addr < ROM) begin
      exp_wr.push_back('{addr, data, cyc + 1, 1'b0});
      if (addr + 1 > m_hwm) m_hwm = addr + 1;
    end else begin
      m_err = 1'b1;
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b0;
    end
  endtask

  task automatic end_download();
    int m;
    @(negedge clk);
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    if (m_hwm == 0) begin
      m_err = 1'b1;
      run_from = -1;
    end else begin
      m = ROM - m_hwm;
      for (int i = 0; i < m; i++) exp_wr.push_back('{m_hwm + i, 0, cyc + 1 + i, 1'b1});
      run_from = cyc + m + HOLD + 1;
      exp_ev.push_back('{1'b0, run_from});
    end
  endtask

  task automatic finish_image(input string tag);
    if (run_from >= 0) wait_until(run_from + 2);
    else repeat (3) @(negedge clk);
    check({tag, "_loaded"}, bus.loaded, (run_from >= 0) ? 1 : 0);
    check({tag, "_cpu_reset"}, bus.cpu_reset, (run_from >= 0) ? 0 : 1);
    check({tag, "_size_err"}, bus.size_err, int'(m_err));
  endtask

  task automatic user_pulse(input int k);
    int u;
    @(negedge clk);
    bus.user_reset = 1'b1;
    u = cyc;
    exp_ev.push_back('{1'b1, u + 1});
    repeat (k) @(negedge clk);
    bus.user_reset = 1'b0;
    run_from = u + k + HOLD;
    exp_ev.push_back('{1'b0, run_from});
    check("user_hold_loaded", bus.loaded, 1);
    check("user_hold_cpu_reset", bus.cpu_reset, 1);
  endtask

  initial begin
    int n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.user_reset     = 1'b0;

    apply_reset("reset");

    start_download();
    for (int a = 0; a < ROM; a++) write_byte(a, $urandom_range(0, 255));
    end_download();
    finish_image("full");

    user_pulse(5);
    finish_image("user");

    start_download();
    for (int a = 0; a < 1000; a++) write_byte(a, $urandom_range(0, 255));
    end_download();
    finish_image("short");

    start_download();
    for (int a = 0; a < 2100; a++) write_byte(a, $urandom_range(0, 255));
    write_byte(16'hFFFF, 8'h5A);
    end_download();
    finish_image("oversize");

    // Empty session; its start must clear the sticky error left by the oversize image.
    start_download();
    repeat (2) @(negedge clk);
    check("restart_size_err", bus.size_err, 0);
    check("restart_loaded", bus.loaded, 0);
    end_download();
    finish_image("empty");

    start_download();
    n = $urandom_range(50, 300);
    for (int i = 0; i < n; i++) write_byte($urandom_range(0, ROM + 100), $urandom_range(0, 255));
    end_download();
    finish_image("random");

    start_download();
    for (int a = 0; a < 100; a++) write_byte(a, $urandom_range(0, 255));
    end_download();
    repeat (50) @(negedge clk);
    check("fill_wait", bus.ioctl_wait, 1);
    start_download();
    repeat (2) @(negedge clk);
    check("abort_wait", bus.ioctl_wait, 0);
    for (int a = 0; a < 10; a++) write_byte(a, $urandom_range(0, 255));
    apply_reset("load_reset");
    repeat (5) @(negedge clk);

    start_download();
    for (int a = 0; a < 200; a++) write_byte(a, $urandom_range(0, 255));
    end_download();
    repeat (30) @(negedge clk);
    apply_reset("fill_reset");
    repeat (5) @(negedge clk);
    check("idle_cpu_reset", bus.cpu_reset, 1);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("ev_queue_drained", exp_ev.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
